// File: rtl/reg_bank_wr_32x64_if.sv
// Write-port and scoreboard bundle for the 32x64 register bank.
// The master drives write/reserve requests; the slave returns the bank contents and busy flags.
interface reg_bank_wr_32x64_if #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT)
);
  logic                                  wr_en_i;
  logic [ADDR_WIDTH-1:0]                 wr_addr_i;
  logic [DATA_WIDTH-1:0]                 wr_data_i;
  logic                                  rsv_en_i;
  logic [ADDR_WIDTH-1:0]                 rsv_addr_i;
  logic [REG_COUNT-1:0][DATA_WIDTH-1:0]  regs_o;
  logic [REG_COUNT-1:0]                  busy_o;
  logic                                  wr_ack_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
    input  regs_o, busy_o, wr_ack_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
    output regs_o, busy_o, wr_ack_o
  );
endinterface

// File: rtl/reg_bank_wr_32x64.sv
// Write side of the 32x64 architectural register file: decoded write enables,
// per-register storage, busy scoreboard and write acknowledge. Register ZERO_REG reads as constant 0.
module reg_bank_wr_32x64 #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  reg_bank_wr_32x64_if.slave    bus
);

  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_all;
  logic [REG_COUNT-1:0]                 busy_all;
  logic                                 wr_ack_reg;
  logic                                 wr_ack_next;

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      if (gi == ZERO_REG) begin : g_zero
        // Hardwired zero: no storage, so writes, reserves and reset have nothing to act on.
        assign regs_all[gi] = '0;
        assign busy_all[gi] = 1'b0;
      end else begin : g_live
        logic                  wr_sel;
        logic                  rsv_sel;
        logic [DATA_WIDTH-1:0] data_reg;
        logic                  busy_reg;

        assign wr_sel  = bus.wr_en_i  && (bus.wr_addr_i  == ADDR_WIDTH'(gi));
        assign rsv_sel = bus.rsv_en_i && (bus.rsv_addr_i == ADDR_WIDTH'(gi));

        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            data_reg <= '0;
            busy_reg <= 1'b0;
          end else begin
            if (wr_sel) begin
              data_reg <= bus.wr_data_i;
            end
            // A new reservation outranks the completing write: the newer producer owns the register.
            if (rsv_sel) begin
              busy_reg <= 1'b1;
            end else if (wr_sel) begin
              busy_reg <= 1'b0;
            end
          end
        end

        assign regs_all[gi] = data_reg;
        assign busy_all[gi] = busy_reg;
      end
    end
  endgenerate

  assign wr_ack_next = bus.wr_en_i && (bus.wr_addr_i != ADDR_WIDTH'(ZERO_REG));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ack_reg <= 1'b0;
    end else begin
      wr_ack_reg <= wr_ack_next;
    end
  end

  assign bus.regs_o   = regs_all;
  assign bus.busy_o   = busy_all;
  assign bus.wr_ack_o = wr_ack_reg;

endmodule

// File: tb/tb_reg_bank_wr_32x64.sv
// Directed bench for reg_bank_wr_32x64: reset, write sweep, zero register,
// scoreboard priority and asynchronous reset in the middle of a burst.
module tb_reg_bank_wr_32x64;

  localparam int DW = 64;
  localparam int RC = 32;
  localparam int AW = 5;
  localparam int ZR = 31;

  logic clk;
  logic rst_n;

  reg_bank_wr_32x64_if #(.DATA_WIDTH(DW), .REG_COUNT(RC), .ADDR_WIDTH(AW)) bus ();

  reg_bank_wr_32x64 #(
    .DATA_WIDTH(DW), .REG_COUNT(RC), .ADDR_WIDTH(AW), .ZERO_REG(ZR)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ack_count = 0;

  logic [RC-1:0][DW-1:0] exp_regs;
  logic [RC-1:0]         exp_busy;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    for (int i = 0; i < RC; i++) begin
      check_eq($sformatf("%s reg%0d", ctx, i), bus.regs_o[i], exp_regs[i]);
    end
    check_eq($sformatf("%s busy", ctx), 64'(bus.busy_o), 64'(exp_busy));
  endtask

  task automatic model_reset();
    exp_regs = '0;
    exp_busy = '0;
  endtask

  // Drive one cycle of stimulus, clock it, update the reference, and compare everything.
  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra, input string ctx);
    logic exp_ack;
    bus.wr_en_i    = we;
    bus.wr_addr_i  = wa;
    bus.wr_data_i  = wd;
    bus.rsv_en_i   = re;
    bus.rsv_addr_i = ra;
    @(posedge clk);
    #1;
    exp_ack = we && (wa != AW'(ZR));
    if (we && wa != AW'(ZR)) begin
      exp_regs[wa] = wd;
      exp_busy[wa] = 1'b0;
    end
    if (re && ra != AW'(ZR)) exp_busy[ra] = 1'b1;
    bus.wr_en_i  = 1'b0;
    bus.rsv_en_i = 1'b0;
    check_eq($sformatf("%s ack", ctx), 64'(bus.wr_ack_o), 64'(exp_ack));
    if (bus.wr_ack_o) ack_count++;
    check_all(ctx);
    $display("%s: we=%0b wa=%0d wd=%h re=%0b ra=%0d -> ack=%0b busy=%h",
             ctx, we, wa, wd, re, ra, bus.wr_ack_o, bus.busy_o);
  endtask

  task automatic idle(input string ctx);
    cycle(1'b0, '0, '0, 1'b0, '0, ctx);
  endtask

  task automatic async_reset_check(input string ctx);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq($sformatf("%s ack", ctx), 64'(bus.wr_ack_o), 64'd0);
    check_all(ctx);
    $display("%s: reset asserted mid-cycle, busy=%h ack=%0b", ctx, bus.busy_o, bus.wr_ack_o);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.wr_en_i    = 1'b0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.rsv_en_i   = 1'b0;
    bus.rsv_addr_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle("post_reset");

    // Preload, then reset asynchronously between edges
    cycle(1'b1, AW'(5), 64'hDEAD_BEEF_0000_0001, 1'b0, '0, "preload5");
    check_eq("preload5 value", bus.regs_o[5], 64'hDEAD_BEEF_0000_0001);
    async_reset_check("reset_async");
    idle("reset_release");

    // Back-to-back write sweep over every storable register
    ack_count = 0;
    for (int k = 0; k < 31; k++) begin
      cycle(1'b1, AW'(k), 64'h0123_4567_89AB_CDEF ^ 64'(k), 1'b0, '0, $sformatf("sweep%0d", k));
    end
    idle("sweep_end");
    check_eq("sweep ack count", 64'(ack_count), 64'd31);
    check_eq("sweep reg30", bus.regs_o[30], 64'h0123_4567_89AB_CDF1);

    // Zero register ignores writes and reservations
    cycle(1'b1, AW'(ZR), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0, "zero_wr");
    check_eq("zero_wr reg31", bus.regs_o[31], 64'd0);
    cycle(1'b0, '0, '0, 1'b1, AW'(ZR), "zero_rsv");
    check_eq("zero_rsv busy31", 64'(bus.busy_o[31]), 64'd0);

    // Scoreboard: reserve 7, write it two cycles later
    cycle(1'b0, '0, '0, 1'b1, AW'(7), "sb_rsv7");
    check_eq("sb busy7 after rsv", 64'(bus.busy_o[7]), 64'd1);
    idle("sb_gap");
    check_eq("sb busy7 held", 64'(bus.busy_o[7]), 64'd1);
    cycle(1'b1, AW'(7), 64'h42, 1'b0, '0, "sb_wr7");
    check_eq("sb busy7 cleared", 64'(bus.busy_o[7]), 64'd0);
    check_eq("sb reg7", bus.regs_o[7], 64'h42);

    // Reserve and write to the same register: data lands, busy stays
    cycle(1'b1, AW'(3), 64'hCAFE_F00D_1234_5678, 1'b1, AW'(3), "same_rw3");
    check_eq("same reg3", bus.regs_o[3], 64'hCAFE_F00D_1234_5678);
    check_eq("same busy3", 64'(bus.busy_o[3]), 64'd1);

    // Reserve 4 while writing a busy 9
    cycle(1'b0, '0, '0, 1'b1, AW'(9), "rsv9");
    cycle(1'b1, AW'(9), 64'h99, 1'b1, AW'(4), "rsv4_wr9");
    check_eq("split busy4", 64'(bus.busy_o[4]), 64'd1);
    check_eq("split busy9", 64'(bus.busy_o[9]), 64'd0);

    // Reset in the middle of a burst with busy bits set
    cycle(1'b1, AW'(10), 64'hA0A0, 1'b1, AW'(12), "burst10");
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = AW'(11);
    bus.wr_data_i = 64'hB1B1;
    async_reset_check("reset_midburst");
    bus.wr_en_i = 1'b0;
    idle("midburst_release");
    cycle(1'b1, AW'(2), 64'h5, 1'b0, '0, "post_wr2");
    check_eq("post reg2", bus.regs_o[2], 64'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank_wr_32x64.md
# reg_bank_wr_32x64

Write side of the CPU's 32-entry, 64-bit register file. It decodes a 5-bit destination address into one of 32 write enables and holds the 32 architectural registers. Register 31 is hardwired to zero. It also keeps a per-register busy scoreboard for in-flight writes. The whole bank is presented as one packed array, which feeds the two Nx32x1 read multiplexers directly.

## Interface
Parameters:
- DATA_WIDTH, 64, width of each register
- REG_COUNT, 32, number of registers; fixed at 32
- ADDR_WIDTH, $clog2(REG_COUNT) = 5, address width
- ZERO_REG, 31, index of the hardwired-zero register

Ports:
- clk_i  input  1  single clock; all state updates on rising edge
- rst_ni  input  1  reset, asynchronous assert, active-low; the polarity and synchronicity are fixed
- wr_en_i  input  1  write strobe for the current cycle
- wr_addr_i  input  ADDR_WIDTH  destination register index
- wr_data_i  input  DATA_WIDTH  write-back data
- rsv_en_i  input  1  reserve strobe: mark a destination busy at issue
- rsv_addr_i  input  ADDR_WIDTH  register to reserve
- regs_o  output  [REG_COUNT-1:0][DATA_WIDTH-1:0]  all register contents, registered; feeds the read muxes
- busy_o  output  REG_COUNT  per-register pending-write flags, registered
- wr_ack_o  output  1  pulses one cycle after an accepted write

## Operation
- Decoder: a 5-to-32 one-hot enable, gated by wr_en_i, forced to 0 when wr_addr_i == ZERO_REG.
- Register array:
  - On a rising edge, if enable[k] is set, reg[k] <= wr_data_i. Otherwise it holds.
  - regs_o[ZERO_REG] is constant 0. It ignores writes and reset. It is never stored as a flop.
- Scoreboard, with per-register priority on each edge:
  - Reserve: rsv_en_i && rsv_addr_i == k && k != ZERO_REG sets busy[k].
  - Else write: enable[k] clears busy[k].
  - Else hold.
  - Reserve and write to the same register in the same cycle leaves busy set. The newer producer owns the register; the data is still written.
- Writes to a non-busy register are legal and update the value. busy does not gate writes.
- wr_ack_o <= wr_en_i && (wr_addr_i != ZERO_REG).
  - A write to ZERO_REG is discarded with no ack.
- Address widths are exact (5 bits, 32 entries), so no out-of-range handling exists.
- Reset (rst_ni low, asynchronous):
  - All stored registers go to 0, busy_o to 0, wr_ack_o to 0, immediately and without waiting for a clock edge.
  - A write coincident with reset release is not required to land. The bench does not drive wr_en_i or rsv_en_i in the first cycle after deassertion.

## Timing
- Write latency is 1 cycle.
  - Data presented at edge N is visible on regs_o after edge N.
  - busy clears after edge N.
  - wr_ack_o is high for the cycle following edge N.
- Reserve latency is 1 cycle: busy_o[k] rises after the edge that samples rsv_en_i.
- No same-cycle write-through: regs_o never reflects wr_data_i before the edge. Any bypassing belongs to the read side.
- Back-to-back writes, one per cycle, are supported with no bubbles. Consecutive writes to the same register: the last write wins.
- The only combinational path is the ZERO_REG constant. Every other output comes straight from a flop.

## Test plan
- Reset:
  - Preload reg[5] = 64'hDEAD_BEEF_0000_0001.
  - Assert rst_ni low mid-cycle.
  - Required: regs_o all 0 and busy_o == 0 before the next clock edge; wr_ack_o = 0.
- Write/readback:
  - Write reg[k] = 64'h0123_4567_89AB_CDEF ^ k for k = 0..30, one per cycle.
  - Required: each value appears one cycle after its edge, wr_ack_o pulses 31 times, and no other register changes.
- Zero register:
  - Write 64'hFFFF_FFFF_FFFF_FFFF to index 31.
  - Required: regs_o[31] stays 0, wr_ack_o stays 0, busy_o[31] stays 0.
  - Reserving index 31 also leaves busy_o[31] at 0.
- Scoreboard:
  - Reserve reg 7, then two cycles later write 64'h42 to reg 7.
  - Required: busy_o[7] is 1 from the cycle after the reserve until the cycle after the write, then 0; regs_o[7] = 64'h42.
- Simultaneous reserve and write to reg 3:
  - Required: regs_o[3] takes the write data and busy_o[3] stays 1.
  - Simultaneous reserve of reg 4 with a write to reg 9: busy_o[4] rises and busy_o[9] clears.
- Reset mid-stream:
  - Assert rst_ni during a burst of writes with busy bits set.
  - Required: everything reads 0 asynchronously.
  - After release, a write of 64'h5 to reg 2 behaves normally.
